// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage, the IF/ID register and downstream stages.
// Latency: none. This package holds only constants and a pure function.
// Backpressure: none.
package fetch_stage_pkg;

  localparam int WORD_W = 32;  // datapath and instruction width
  localparam int INSTR_W = WORD_W;  // IF/ID instruction field
  localparam int PC4_W = WORD_W;  // IF/ID PC+4 field

  // sll $0,$0,0 -- architecturally a no-op, used as the bubble encoding
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Force a byte address onto a word boundary. Misaligned targets are
  // silently truncated rather than trapped.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and flush controls. The same pattern is reused for ID/EX and EX/MEM.
// Latency: 1 cycle from d_* to the registered outputs.
// Backpressure: hold freezes the contents, and flush (higher priority) inserts a NOP bubble.
// Ports: clk, reset (async, active-high), hold, flush, d_instr/d_pc4/d_valid in,
//        instr/pc4/valid out.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC4_W-1:0]   d_pc4,
  input  logic               d_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC4_W-1:0]   pc4,
  output logic               valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      // pc4 is deliberately left alone on flush. Nothing consumes it while valid is low.
      instr <= NOP;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= d_instr;
      pc4   <= d_pc4;
      valid <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: it owns the PC, addresses instruction memory and fills IF/ID.
// Latency: the instruction at pc appears on if_id_instr 1 cycle later, and a redirect costs 1 bubble.
// Backpressure: stall holds the PC, IF/ID and fetch_count. A redirect overrides stall.
// Ports: clk, reset (async, active-high), stall, redirect, redirect_pc, imem_addr/imem_rdata
//        (combinational read), pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0]  RESET_PC   = 32'h0000_0000,
  parameter int                 IMEM_DEPTH = 64,
  parameter logic [INSTR_W-1:0] NOP        = NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [WORD_W-1:0]             redirect_pc,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [INSTR_W-1:0]            imem_rdata,
  output logic [WORD_W-1:0]             pc,
  output logic [INSTR_W-1:0]            if_id_instr,
  output logic [PC4_W-1:0]              if_id_pc4,
  output logic                          if_id_valid,
  output logic [WORD_W-1:0]             fetch_count
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [WORD_W-1:0] pc_plus4;
  logic              unused_lo;

  assign pc_plus4 = pc + 32'd4;  // wraps modulo 2^32

  // The upper PC bits are ignored, so fetches beyond the memory wrap back to word 0.
  assign imem_addr = pc[AW+1:2];

  // The low target bits are dropped by word_align. This tie-off keeps them visibly consumed.
  assign unused_lo = ^redirect_pc[1:0];

  // PC register and fetch counter. The priority order is redirect, then stall, then advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else if (redirect) begin
      pc <= word_align(redirect_pc);
    end else if (!stall) begin
      pc          <= pc_plus4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  if_id_reg #(
    .NOP(NOP)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .hold   (stall),
    .flush  (redirect),
    .d_instr(imem_rdata),
    .d_pc4  (pc_plus4),
    .d_valid(1'b1),
    .instr  (if_id_instr),
    .pc4    (if_id_pc4),
    .valid  (if_id_valid)
  );

endmodule
